// File: rtl/midi_cmd_sequencer_pkg.sv
// Shared definitions for the MIDI command sequencer: command word layout,
// reserved codes and the issue FSM state type.
package midi_cmd_sequencer_pkg;

  localparam int unsigned CMD_W    = 16;
  localparam int unsigned CMD_BIT  = 15;
  localparam int unsigned MIDI_MSB = 14;
  localparam int unsigned MIDI_LSB = 8;
  localparam int unsigned VEL_MSB  = 7;
  localparam int unsigned VEL_LSB  = 0;

  localparam logic [6:0]       MIDI_STOP_ALL = 7'h7F;
  localparam logic [CMD_W-1:0] IDLE_WORD     = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } seq_state_e;

  function automatic logic [6:0] midi_field(input logic [CMD_W-1:0] w);
    return w[MIDI_MSB:MIDI_LSB];
  endfunction

  function automatic logic is_stop_all(input logic [CMD_W-1:0] w);
    return !w[CMD_BIT] && (midi_field(w) == MIDI_STOP_ALL);
  endfunction

endpackage

// File: rtl/midi_cmd_sequencer_if.sv
// Host write port and bank-manager output bus of the MIDI command sequencer.
interface midi_cmd_sequencer_if
  import midi_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             i_wr;
  logic [CMD_W-1:0] i_wdata;
  logic [CMD_W-1:0] o_data;
  logic             o_full;
  logic [LVL_W-1:0] o_level;
  logic             o_overflow;
  logic             o_reject;

  modport master (
    output i_wr, i_wdata,
    input  o_data, o_full, o_level, o_overflow, o_reject
  );

  modport slave (
    input  i_wr, i_wdata,
    output o_data, o_full, o_level, o_overflow, o_reject
  );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered level/full and a flush that can coincide
// with a push (the pushed word then lands alone in entry 0).
module cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_d;

  assign rdata = mem[rd_ptr];
  assign empty = (level == '0);

  always_comb begin
    level_d = level;
    if (flush) begin
      level_d = (AW+1)'(push);
    end else begin
      case ({push, pop})
        2'b10:   level_d = level + 1'b1;
        2'b01:   level_d = level - 1'b1;
        default: level_d = level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      // A same-cycle pop consumed the old head already; flush restarts at 0.
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= AW'(push);
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_d;
      full  <= (level_d == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[flush ? '0 : wr_ptr] <= wdata;
  end

endmodule

// File: rtl/midi_cmd_sequencer.sv
// Buffers host note commands and replays each as a one-cycle word followed by
// GAP idle cycles. Optional feature macro: CMD_FLUSH_PRIORITY_EN.
module midi_cmd_sequencer
  import midi_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP   = 2
) (
  input logic                 clk,
  input logic                 i_rst_n,
  midi_cmd_sequencer_if.slave bus
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = (GAP > 1) ? $clog2(GAP) : 1;

  logic [CMD_W-1:0] head;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic             push;
  logic             pop;
  logic             flush;
  logic             midi_zero;

  seq_state_e       state_q, state_d;
  logic [CMD_W-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q;
  logic             rej_q;

  assign midi_zero = (midi_field(bus.i_wdata) == '0);

`ifdef CMD_FLUSH_PRIORITY_EN
  assign flush = bus.i_wr && is_stop_all(bus.i_wdata);
`else
  assign flush = 1'b0;
`endif

  // Full is the pre-pop registered flag, so a same-cycle pop cannot rescue a write.
  assign push = bus.i_wr && !midi_zero && (!full || flush);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.i_wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    state_d = state_q;
    data_d  = IDLE_WORD;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CW'(GAP - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= IDLE_WORD;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= bus.i_wr && !midi_zero && full && !flush;
      rej_q   <= bus.i_wr && midi_zero;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_full     = full;
  assign bus.o_level    = level;
  assign bus.o_overflow = ovf_q;
  assign bus.o_reject   = rej_q;

endmodule

// File: doc/midi_cmd_sequencer.md
# midi_cmd_sequencer

Upstream feeder for the voice bank manager. Accepts 16-bit note commands from the host-side write port and buffers them in a small FIFO. Replays each command onto the bank manager's `i_data` bus as a single-cycle word, followed by a mandatory run of idle zeros. This guarantees the bank manager never sees a held command (which would allocate extra banks) and never sees two commands closer together than its minimum spacing.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `GAP`, 2: idle (all-zero) cycles forced after every issued word; ≥1.
- `clk` in 1: single system clock; all logic on rising edge.
- `i_rst_n` in 1: asynchronous active-low reset; deassertion is synchronised externally.
- `i_wr` in 1: host write strobe, one word per cycle high.
- `i_wdata` in 16: command word. Bit 15 is cmd (1=START, 0=STOP), bits 14:8 are MIDI note, bits 7:0 are velocity.
- `o_data` out 16: to bank manager `i_data`; 16'h0000 when idle.
- `o_full` out 1: FIFO holds `DEPTH` entries.
- `o_level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `o_overflow` out 1: one-cycle pulse, write dropped because FIFO full.
- `o_reject` out 1: one-cycle pulse, write dropped because MIDI field is 0.

## Operation
- Word acceptance: `i_wr` high, MIDI field ≠ 0, FIFO not full → push. MIDI 0 is never a legal note; 16'h0000 is the idle code.
  - MIDI field = 0 → drop, pulse `o_reject`. Velocity and cmd bits are ignored for this check.
  - FIFO full → drop, pulse `o_overflow`. This holds even if a pop happens in the same cycle; the full flag is sampled before the pop.
  - A reject takes priority over an overflow; only one pulse fires per write.
- FSM, three states:
  - IDLE: `o_data`=0. FIFO non-empty → pop the head, load it into the `o_data` register, go to ISSUE.
  - ISSUE: held for exactly one cycle. Next state is GAP with `o_data`←0 and the gap counter loaded with `GAP-1`.
  - GAP: `o_data`=0. Counter decrements each cycle. At 0 → IDLE.
- The IDLE state is transparent when the FIFO is non-empty: the pop happens in IDLE's cycle, so the issue period is GAP+2 cycles (default 4).
- A STOP_ALL word (bit 15=0, MIDI=7'h7F) is an ordinary entry and is issued in FIFO order.
- Push and pop in the same cycle: occupancy is unchanged and both take effect. Pointers wrap modulo `DEPTH`; `o_level` is the exact count from 0 to `DEPTH`.
- Reset (asserted at any time, including mid-ISSUE or mid-GAP): FIFO emptied, pointers 0, FSM IDLE, counter 0. All outputs are 0: `o_data`=16'h0000, `o_full`=0, `o_level`=0, `o_overflow`=0, `o_reject`=0.

## Timing
- All outputs are registered.
- Write at edge n into an empty FIFO with the FSM in IDLE:
  - `o_level`=1 after edge n.
  - Pop at edge n+1; the word appears on `o_data` after edge n+1 and lasts one cycle.
  - `o_level` is back to 0 after edge n+1.
- Write-to-output latency is 2 edges minimum.
- Back-to-back queued words appear on `o_data` every GAP+2 cycles, with exactly GAP+1 zero cycles between them.
- `o_overflow` and `o_reject` are high in the cycle after the offending write edge.
- `o_full` updates in the same cycle as `o_level`.

## Configuration
- `CMD_FLUSH_PRIORITY_EN` defined:
  - A STOP_ALL write is never dropped for full.
  - It clears the FIFO, discarding pending words without pulsing `o_overflow`, then occupies entry 0 alone (`o_level`=1).
  - It is issued at the next IDLE opportunity. An in-progress ISSUE/GAP sequence still completes normally.
- Undefined: STOP_ALL is queued like any other word and is subject to overflow.

## Structure
- Shared synth package holds:
  - command field positions (`CMD_BIT`=15, `MIDI_MSB`/`LSB`=14/8, `VEL_MSB`/`LSB`=7/0);
  - `MIDI_STOP_ALL`=7'h7F;
  - `IDLE_WORD`=16'h0000;
  - the FSM state enum.
- One sub-module, `cmd_fifo`: a synchronous FIFO with `DEPTH`/width parameters, push/pop/flush inputs, and full/empty/level outputs. The sequencer instantiates it and owns the FSM and gap counter.

## Test plan
- Reset mid-GAP with 3 words queued → next cycle all outputs 0, `o_level`=0; no word is issued after release.
- Single write 16'h8A45 into empty → `o_data`=8A45 for exactly one cycle, 2 edges after the write; then `o_data`=0.
- Four writes on consecutive cycles (8A45, 8B40, 0A00, 0B00) → same order on `o_data`, each one cycle wide, with 3 zero cycles between each (GAP=2).
- Write 16'h0055 (MIDI 0) → `o_reject` pulse, `o_level` unchanged, nothing issued.
- Ten writes into DEPTH=8 while the sequencer is stalled in GAP → `o_full`=1, two `o_overflow` pulses, first eight words issued in order.
- `CMD_FLUSH_PRIORITY_EN` with a full FIFO, then write 16'h7F00 → no overflow, `o_level`=1, next issued word is 7F00, then idle.
